// File: rtl/lcd_scheduler.sv
// lcd_scheduler: owns the HD44780 4-bit bus. Runs the power-on init sequence,
// then shares the panel round-robin between the POST and local byte sources,
// strobing each byte out as two nibbles and enforcing execution delays.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// PWRON      | power-on settle before the first init nibble
// INIT_SETUP | init nibble on bus, E low
// INIT_EHIGH | init nibble strobe, E high
// INIT_HOLD  | init nibble hold, E low
// INIT_WAIT  | post-nibble delay of the init sequence
// IDLE       | accepting a byte from the arbitration winner
// SETUP      | byte nibble on bus, E low
// EHIGH      | byte nibble strobe, E high
// HOLD       | byte nibble hold, E low
// WAIT       | controller execution delay after the low nibble
module lcd_scheduler #(
    parameter int unsigned E_HIGH_CYCLES    = 1,
    parameter int unsigned CMD_WAIT_CYCLES  = 80,
    parameter int unsigned CLR_WAIT_CYCLES  = 3280,
    parameter int unsigned INIT_WAIT_CYCLES = 8200,
    parameter int unsigned POWERON_CYCLES   = 30000
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       post_valid,
    input  logic [7:0] post_data,
    input  logic       post_rs,
    output logic       post_ready,
    input  logic       loc_valid,
    input  logic [7:0] loc_data,
    input  logic       loc_rs,
    output logic       loc_ready,
    output logic [3:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic       busy
);

    typedef enum logic [3:0] {
        PWRON,
        INIT_SETUP,
        INIT_EHIGH,
        INIT_HOLD,
        INIT_WAIT,
        IDLE,
        SETUP,
        EHIGH,
        HOLD,
        WAIT
    } state_t;

    // Counter reload values: a timed state lasts (load + 1) cycles.
    localparam logic [15:0] E_LOAD    = 16'(E_HIGH_CYCLES - 1);
    localparam logic [15:0] CMD_LOAD  = 16'(CMD_WAIT_CYCLES - 1);
    localparam logic [15:0] CLR_LOAD  = 16'(CLR_WAIT_CYCLES - 1);
    localparam logic [15:0] IW_LOAD   = 16'(INIT_WAIT_CYCLES - 1);
    localparam logic [15:0] PWR_LOAD  = 16'(POWERON_CYCLES - 1);

    // Items 0-3 are bare nibbles (low half used), 4-7 are full instruction bytes.
    function automatic logic [7:0] init_item(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_item = 8'h03;
            3'd3:             init_item = 8'h02;
            3'd4:             init_item = 8'h28;
            3'd5:             init_item = 8'h0C;
            3'd6:             init_item = 8'h01;
            default:          init_item = 8'h06;
        endcase
    endfunction

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic        cnt_zero;
    logic [7:0]  byte_q;
    logic        rs_q;
    logic        low_half;
    logic        prefer_loc;
    // Index of the init item most recently put on the bus; 7 out of reset so
    // the first increment wraps to item 0, and it stays at 7 once init is done.
    logic [2:0]  init_idx;
    logic [7:0]  init_next;
    logic        handshake;
    logic [7:0]  hs_data;
    logic        hs_rs;
    logic        is_clear_home;
    logic [15:0] wait_load;

    assign cnt_zero      = (cnt == 16'd0);
    assign init_next     = init_item(init_idx + 3'd1);
    assign handshake     = post_ready | loc_ready;
    assign hs_data       = post_ready ? post_data : loc_data;
    assign hs_rs         = post_ready ? post_rs : loc_rs;
    assign is_clear_home = !rs_q && (byte_q >= 8'd1) && (byte_q <= 8'd3);
    assign wait_load     = is_clear_home ? CLR_LOAD : CMD_LOAD;

    // State register.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) state <= PWRON;
        else       state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            PWRON:      if (cnt_zero) next_state = INIT_SETUP;
            INIT_SETUP: next_state = INIT_EHIGH;
            INIT_EHIGH: if (cnt_zero) next_state = INIT_HOLD;
            INIT_HOLD:  next_state = INIT_WAIT;
            INIT_WAIT:  if (cnt_zero) next_state = (init_idx == 3'd3) ? SETUP : INIT_SETUP;
            IDLE:       if (handshake) next_state = SETUP;
            SETUP:      next_state = EHIGH;
            EHIGH:      if (cnt_zero) next_state = HOLD;
            HOLD:       next_state = low_half ? WAIT : SETUP;
            WAIT:       if (cnt_zero) next_state = (init_idx < 3'd7) ? SETUP : IDLE;
            default:    next_state = PWRON;
        endcase
    end

    // Arbitration and status outputs; readies only exist in IDLE.
    always_comb begin
        post_ready = 1'b0;
        loc_ready  = 1'b0;
        busy       = (state != IDLE);
        if (state == IDLE) begin
            post_ready = post_valid && (!loc_valid || !prefer_loc);
            loc_ready  = loc_valid && (!post_valid || prefer_loc);
        end
    end

    // Shared delay down-counter, reloaded on entry to each timed state.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            cnt <= PWR_LOAD;
        end else if (next_state != state) begin
            case (next_state)
                INIT_EHIGH, EHIGH: cnt <= E_LOAD;
                INIT_WAIT:         cnt <= IW_LOAD;
                WAIT:              cnt <= wait_load;
                default:           cnt <= 16'd0;
            endcase
        end else if (!cnt_zero) begin
            cnt <= cnt - 16'd1;
        end
    end

    // Bus datapath: byte latch, nibble select, init sequencing and E strobe.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            lcd_e      <= 1'b0;
            lcd_data   <= 4'd0;
            lcd_rs     <= 1'b0;
            byte_q     <= 8'd0;
            rs_q       <= 1'b0;
            low_half   <= 1'b0;
            prefer_loc <= 1'b0;
            init_idx   <= 3'd7;
        end else begin
            lcd_e <= (next_state == EHIGH) || (next_state == INIT_EHIGH);
            if (state == IDLE && handshake) begin
                byte_q     <= hs_data;
                rs_q       <= hs_rs;
                lcd_data   <= hs_data[7:4];
                lcd_rs     <= hs_rs;
                low_half   <= 1'b0;
                prefer_loc <= post_ready;
            end
            if (next_state == INIT_SETUP && state != INIT_SETUP) begin
                lcd_data <= init_next[3:0];
                lcd_rs   <= 1'b0;
                init_idx <= init_idx + 3'd1;
            end
            if (next_state == SETUP && (state == INIT_WAIT || state == WAIT)) begin
                byte_q   <= init_next;
                rs_q     <= 1'b0;
                lcd_data <= init_next[7:4];
                lcd_rs   <= 1'b0;
                low_half <= 1'b0;
                init_idx <= init_idx + 3'd1;
            end
            if (next_state == SETUP && state == HOLD) begin
                lcd_data <= byte_q[3:0];
                low_half <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_scheduler.sv
// Scoreboard bench for lcd_scheduler: stimulus pushes expected grants, strobed
// nibbles and busy-run lengths; an independent monitor pops and compares.
module tb_lcd_scheduler;

    localparam int E_HIGH = 1;
    localparam int CMD_W  = 3;
    localparam int CLR_W  = 7;
    localparam int INIT_W = 5;
    localparam int PWR    = 10;
    // PWRON 10 + 4 nibbles x (1+1+1+5) + bytes 28/0C/06 x 9 + byte 01 x 13
    localparam int INIT_BUSY = 82;

    logic       refclk = 1'b0;
    logic       reset  = 1'b1;
    logic       post_valid = 1'b0;
    logic [7:0] post_data  = 8'h00;
    logic       post_rs    = 1'b0;
    logic       post_ready;
    logic       loc_valid  = 1'b0;
    logic [7:0] loc_data   = 8'h00;
    logic       loc_rs     = 1'b0;
    logic       loc_ready;
    logic [3:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_e;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_strobe_q[$];
    bit         exp_grant_q[$];
    int         exp_busy_q[$];

    always #5 refclk = ~refclk;

    lcd_scheduler #(
        .E_HIGH_CYCLES   (E_HIGH),
        .CMD_WAIT_CYCLES (CMD_W),
        .CLR_WAIT_CYCLES (CLR_W),
        .INIT_WAIT_CYCLES(INIT_W),
        .POWERON_CYCLES  (PWR)
    ) dut (
        .refclk    (refclk),
        .reset     (reset),
        .post_valid(post_valid),
        .post_data (post_data),
        .post_rs   (post_rs),
        .post_ready(post_ready),
        .loc_valid (loc_valid),
        .loc_data  (loc_data),
        .loc_rs    (loc_rs),
        .loc_ready (loc_ready),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .busy      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input bit src, input logic [7:0] d, input bit rs, input int wait_c);
        exp_grant_q.push_back(src);
        exp_strobe_q.push_back({rs, d[7:4]});
        exp_strobe_q.push_back({rs, d[3:0]});
        exp_busy_q.push_back(2 * (2 + E_HIGH) + wait_c);
    endtask

    task automatic push_init();
        exp_strobe_q.push_back(5'h03);
        exp_strobe_q.push_back(5'h03);
        exp_strobe_q.push_back(5'h03);
        exp_strobe_q.push_back(5'h02);
        exp_strobe_q.push_back(5'h02);
        exp_strobe_q.push_back(5'h08);
        exp_strobe_q.push_back(5'h00);
        exp_strobe_q.push_back(5'h0C);
        exp_strobe_q.push_back(5'h00);
        exp_strobe_q.push_back(5'h01);
        exp_strobe_q.push_back(5'h00);
        exp_strobe_q.push_back(5'h06);
        exp_busy_q.push_back(INIT_BUSY);
    endtask

    // Present a byte from one requester and hold it until the handshake edge.
    task automatic send(input bit src, input logic [7:0] d, input bit rs);
        bit done = 0;
        @(posedge refclk);
        #1;
        if (src) begin loc_valid = 1'b1; loc_data = d; loc_rs = rs; end
        else     begin post_valid = 1'b1; post_data = d; post_rs = rs; end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge refclk);
            #1;
            if ((src && loc_ready) || (!src && post_ready)) begin
                @(posedge refclk);
                #1;
                post_valid = 1'b0;
                loc_valid  = 1'b0;
                done = 1;
            end
        end
        check("send_handshake", int'(done), 1);
        post_valid = 1'b0;
        loc_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge refclk);
            if (!busy) break;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge refclk);
        @(posedge refclk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic       prev_e;
        logic [4:0] cap;
        logic [4:0] exp_s;
        int         ehigh;
        int         run;
        prev_e = 1'b0;
        cap    = 5'd0;
        ehigh  = 0;
        run    = 0;
        forever begin
            @(negedge refclk);
            if (reset) begin
                prev_e = lcd_e;
                run    = 0;
                ehigh  = 0;
                continue;
            end
            if (post_ready || loc_ready) begin
                check("single_ready", int'(post_ready && loc_ready), 0);
                check("grant_expected", int'(exp_grant_q.size() > 0), 1);
                if (exp_grant_q.size() > 0)
                    check("grant_src", int'(loc_ready), int'(exp_grant_q.pop_front()));
            end
            if (lcd_e && !prev_e) begin
                check("strobe_expected", int'(exp_strobe_q.size() > 0), 1);
                if (exp_strobe_q.size() > 0) begin
                    exp_s = exp_strobe_q.pop_front();
                    check("strobe_rs_nibble", int'({lcd_rs, lcd_data}), int'(exp_s));
                end
                cap   = {lcd_rs, lcd_data};
                ehigh = 0;
            end
            if (lcd_e) ehigh++;
            if (!lcd_e && prev_e) begin
                check("e_width", ehigh, E_HIGH);
                check("hold_stable", int'({lcd_rs, lcd_data}), int'(cap));
            end
            if (busy) begin
                run++;
            end else if (run > 0) begin
                check("busy_expected", int'(exp_busy_q.size() > 0), 1);
                if (exp_busy_q.size() > 0)
                    check("busy_length", run, exp_busy_q.pop_front());
                run = 0;
            end
            prev_e = lcd_e;
        end
    end

    initial begin
        int grants;
        @(posedge refclk);
        @(posedge refclk);
        #1;
        check("rst_lcd_e", int'(lcd_e), 0);
        check("rst_lcd_data", int'(lcd_data), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_post_ready", int'(post_ready), 0);
        check("rst_loc_ready", int'(loc_ready), 0);
        check("rst_busy", int'(busy), 1);

        // Power-on init with no requests.
        push_init();
        reset = 1'b0;
        wait_idle("init_idle", 500);
        check("init_strobes_done", exp_strobe_q.size(), 0);

        // Single POST data byte.
        push_byte(1'b0, 8'h41, 1'b1, CMD_W);
        send(1'b0, 8'h41, 1'b1);
        wait_idle("post_41_idle", 100);

        // Clear with RS=0 takes the long wait, same byte as data does not.
        push_byte(1'b1, 8'h01, 1'b0, CLR_W);
        send(1'b1, 8'h01, 1'b0);
        wait_idle("loc_clr_idle", 100);
        push_byte(1'b1, 8'h01, 1'b1, CMD_W);
        send(1'b1, 8'h01, 1'b1);
        wait_idle("loc_data01_idle", 100);

        // Both requesting continuously; last grant was local so POST leads.
        push_byte(1'b0, 8'h30, 1'b1, CMD_W);
        push_byte(1'b1, 8'h31, 1'b1, CMD_W);
        push_byte(1'b0, 8'h30, 1'b1, CMD_W);
        push_byte(1'b1, 8'h31, 1'b1, CMD_W);
        @(posedge refclk);
        #1;
        post_data = 8'h30; post_rs = 1'b1; post_valid = 1'b1;
        loc_data  = 8'h31; loc_rs  = 1'b1; loc_valid  = 1'b1;
        grants = 0;
        for (int i = 0; i < 300 && grants < 4; i++) begin
            @(negedge refclk);
            #1;
            if (post_ready || loc_ready) begin
                grants++;
                if (grants == 4) begin
                    @(posedge refclk);
                    #1;
                    post_valid = 1'b0;
                    loc_valid  = 1'b0;
                end
            end
        end
        post_valid = 1'b0;
        loc_valid  = 1'b0;
        check("rr_grant_count", grants, 4);
        wait_idle("rr_idle", 100);

        // A request pulsed while busy is dropped.
        push_byte(1'b1, 8'h55, 1'b1, CMD_W);
        send(1'b1, 8'h55, 1'b1);
        @(posedge refclk);
        #1;
        post_data = 8'hA5; post_rs = 1'b1; post_valid = 1'b1;
        @(posedge refclk);
        #1;
        post_valid = 1'b0;
        wait_idle("pulse_idle", 100);
        repeat (6) @(negedge refclk);
        check("pulse_no_grant", exp_grant_q.size(), 0);
        check("pulse_no_strobe", exp_strobe_q.size(), 0);

        // Reset while E is high mid-byte: only the high nibble ever appears.
        exp_grant_q.push_back(1'b0);
        exp_strobe_q.push_back({1'b1, 4'h7});
        send(1'b0, 8'h7E, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge refclk);
            if (lcd_e) break;
        end
        check("mid_byte_e_seen", int'(lcd_e), 1);
        #2;
        reset = 1'b1;
        #1;
        check("reset_e_async", int'(lcd_e), 0);
        check("reset_busy", int'(busy), 1);
        push_init();
        do_reset();
        wait_idle("reinit_idle", 500);
        repeat (12) @(negedge refclk);

        check("final_strobe_q", exp_strobe_q.size(), 0);
        check("final_grant_q", exp_grant_q.size(), 0);
        check("final_busy_q", exp_busy_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
